stoch_mult_engine: RTL

//  Parametrised stochastic-computing multiplier with windowed binary readback.
//  Two 31-bit LFSRs drive comparators that turn PW-bit probabilities into bit streams.
//  The streams are multiplied by AND (unipolar) or XNOR (bipolar), and the 1s are

---
 rtl/stoch_mult_engine.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/stoch_mult_engine.sv
// Purpose: stochastic multiplier. Two LFSR-driven comparators turn PW-bit probabilities into
//          bit streams. The streams are ANDed (unipolar) or XNORed (bipolar) and the 1s are
//          counted over a 2^WIN_LOG2-bit window.
// Latency: result_valid rises 2^WIN_LOG2+2 cycles after the accept edge (2 fill + window).
// Backpressure: none. Results are never stalled. An unacknowledged result is overwritten
//          and the sticky overrun flag is set.
// Ports:   clk, rst_n (async active-HIGH reset), start/cont/mode/prob_a/prob_b (control and
//          operands), busy, result/result_valid/result_ack (result handshake), overrun.
module stoch_mult_engine #(
  parameter int          PW       = 4,
  parameter int          WIN_LOG2 = 7,
  parameter logic [30:0] SEED_A   = 31'd1,
  parameter logic [30:0] SEED_B   = 31'd2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                cont,
  input  logic                mode,
  input  logic [PW-1:0]       prob_a,
  input  logic [PW-1:0]       prob_b,
  output logic                busy,
  output logic [WIN_LOG2:0]   result,
  output logic                result_valid,
  input  logic                result_ack,
  output logic                overrun
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  localparam logic [WIN_LOG2-1:0] SAMP_ONE = {{(WIN_LOG2-1){1'b0}}, 1'b1};

  // x^31 + x^28 + 1, shift left, feedback enters at bit 0
  function automatic logic [30:0] f_lfsr_step(input logic [30:0] q);
    return {q[29:0], q[27] ^ q[30]};
  endfunction

  logic [1:0]          r_state;
  logic [30:0]         r_lfsr_a;
  logic [30:0]         r_lfsr_b;
  logic [PW-1:0]       r_op_a;
  logic [PW-1:0]       r_op_b;
  logic                r_mode;
  logic                r_s1_a;
  logic                r_s1_b;
  logic                r_s2_m;
  logic                r_fill;
  logic [WIN_LOG2-1:0] r_samp;
  logic [WIN_LOG2:0]   r_ones;
  logic [WIN_LOG2:0]   r_result;
  logic                r_valid;
  logic                r_overrun;

  logic                w_accept;
  logic                w_done;
  logic [WIN_LOG2:0]   w_sum;

  assign w_accept = (r_state == S_IDLE) && start;
  // The last sample of the window is being added on this edge
  assign w_done   = (r_state == S_RUN) && (r_samp == {WIN_LOG2{1'b1}});
  // Counter is one bit wider than the window index, so a full window of 1s fits without wrap
  assign w_sum    = r_ones + {{WIN_LOG2{1'b0}}, r_s2_m};

  // LFSRs and the two pipeline stages run every cycle regardless of state
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_lfsr_a <= SEED_A;
      r_lfsr_b <= SEED_B;
      r_s1_a   <= 1'b0;
      r_s1_b   <= 1'b0;
      r_s2_m   <= 1'b0;
    end else begin
      r_lfsr_a <= f_lfsr_step(r_lfsr_a);
      r_lfsr_b <= f_lfsr_step(r_lfsr_b);
      r_s1_a   <= (r_lfsr_a[PW-1:0] < r_op_a);
      r_s1_b   <= (r_lfsr_b[PW-1:0] < r_op_b);
      r_s2_m   <= r_mode ? ~(r_s1_a ^ r_s1_b) : (r_s1_a & r_s1_b);
    end
  end

  // Control FSM and window counters
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state <= S_IDLE;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_mode  <= 1'b0;
      r_fill  <= 1'b0;
      r_samp  <= '0;
      r_ones  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op_a  <= prob_a;
            r_op_b  <= prob_b;
            r_mode  <= mode;
            r_fill  <= 1'b0;
            r_samp  <= '0;
            r_ones  <= '0;
            r_state <= S_FILL;
          end
        end
        S_FILL: begin
          // S2 output during these two cycles still reflects stale operands
          if (r_fill) begin
            r_state <= S_RUN;
          end else begin
            r_fill <= 1'b1;
          end
        end
        S_RUN: begin
          r_ones <= w_sum;
          r_samp <= r_samp + SAMP_ONE;
          if (w_done) begin
            if (cont) begin
              r_op_a  <= prob_a;
              r_op_b  <= prob_b;
              r_mode  <= mode;
              r_fill  <= 1'b0;
              r_samp  <= '0;
              r_ones  <= '0;
              r_state <= S_FILL;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Result register, handshake and sticky overrun
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_result  <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_done) begin
        // Completion wins over a same-edge ack: the new result stays valid
        r_result <= w_sum;
        r_valid  <= 1'b1;
        if (r_valid && !result_ack) begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && result_ack) begin
        r_valid <= 1'b0;
      end
      // Accept only happens in IDLE, so it never coincides with a completion
      if (w_accept) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign busy         = (r_state == S_FILL) || (r_state == S_RUN);
  assign result       = r_result;
  assign result_valid = r_valid;
  assign overrun      = r_overrun;

endmodule
